max_reduce_ctrl: RTL
====================

// Module: max_reduce_ctrl
// PURPOSE
//  Streaming arg-max scheduler built around the 4-operand max datapath. Accepts a frame of WIDTH-bit
//  words over a valid/ready stream, stages them in groups of 4, runs one 4-way compare per group and
//  folds the result into a running maximum. Emits the frame maximum and its in-frame index once per
//  frame. Sits between the operand source and the result consumer.
// PARAMETERS
//  WIDTH  128  operand width in bits
//  IDX_W  16   width of in-frame word index and frame counter
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      asynchronous, active-high reset
//  s_valid  in   1      input word valid
//  s_ready  out  1      block can accept a word this cycle
//  s_data   in   WIDTH  input word
//  s_last   in   1      final word of frame, qualified by s_valid&s_ready
//  m_valid  out  1      result valid, held until accepted
//  m_ready  in   1      consumer accepts result
//  m_max    out  WIDTH  frame maximum
//  m_idx    out  IDX_W  index of the first word in the frame equal to m_max
//  m_ovf    out  1      frame exceeded 2^IDX_W words; m_idx saturated
// BEHAVIOUR
//  - Reset (async, any state): FSM=FILL, slot count=0, frame count=0, running max cleared, first-group
//    flag set, s_ready=0 while rst high then 1, m_valid=0, m_max=0, m_idx=0, m_ovf=0.
//    A partial frame in flight is discarded.
//  - FSM FILL: s_ready=1. On handshake, write word to slot[cnt] and mark the slot valid. Go to EVAL
//    when the 4th slot fills or s_last is accepted; else stay in FILL.
//  - FSM EVAL (1 cycle, s_ready=0):
//    - 4-way max over the valid slots; invalid slots never win.
//    - Tie: lowest slot wins.
//    - Group max replaces the running max if this is the first group or group max > running max.
//      Tie keeps the running max, so the earliest index wins.
//    - Index = group_base + winning slot.
//    - Then: if last seen, go to DONE; else clear slots, group_base += 4, go to FILL.
//  - FSM DONE: m_valid=1; m_max/m_idx/m_ovf stable. On m_ready, go to FILL with frame state cleared
//    and m_valid=0 next cycle.
//  - Latency: last word accepted at cycle t -> EVAL at t+1 -> m_valid at t+2. Throughput: 4 words per
//    5 cycles; one frame result per DONE.
//  - Frame with 1-3 words: single EVAL with partially filled slots. A 1-word frame yields m_idx=0.
//  - group_base saturates at 2^IDX_W-1; m_ovf set sticky for the frame. Compare results stay exact;
//    m_idx is saturated.
//  - s_last with s_valid=0 or s_ready=0 is ignored. No empty frames exist (last is carried on a word).
//  - Outputs are registered; no combinational path from s_* or m_ready to any output.
// CONFIGURATION
//  MAXR_SIGNED_EN defined: all compares (slot and running max) treat operands as two's complement
//    signed.
//  MAXR_SIGNED_EN undefined: unsigned compares.
//  Ports and timing are identical in both builds.
// TESTING
//  - Single word 5 with last -> m_valid at t+2, m_max=5, m_idx=0, m_ovf=0.
//  - Frame {3,9,9,1,7,9} (6 words, 2 groups) -> m_max=9, m_idx=1 (earliest tie across and within
//    groups).
//  - Frame {2^127, 1}:
//    - unsigned build -> m_max=2^127, m_idx=0.
//    - MAXR_SIGNED_EN build -> m_max=1, m_idx=1.
//  - Result backpressure: m_ready low 10 cycles -> m_valid and outputs stable, s_ready=0.
//    m_ready pulse -> next frame {4,8} gives m_max=8, m_idx=1.
//  - rst asserted after 3 words of a frame -> all outputs 0 immediately. New frame {6} -> m_max=6,
//    m_idx=0.
//  - IDX_W=3, 10-word frame with max at word 9 -> m_ovf=1, m_idx=7, m_max correct.

Source files
------------

// File: rtl/max_reduce_ctrl.sv
// rtl/max_reduce_ctrl.sv - streaming arg-max over a frame, one 4-way compare per staged group of words
// Optional build macro: MAXR_SIGNED_EN (two's complement compares when defined, unsigned otherwise).
module max_reduce_ctrl #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_max,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_ovf
);

    typedef enum logic [1:0] {FILL, EVAL, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] slot [4];
    logic [3:0]       slot_vld;
    logic [1:0]       cnt;
    logic             last_seen;
    logic             first_grp;
    logic [WIDTH-1:0] run_max;
    logic [IDX_W-1:0] run_idx;
    logic [IDX_W-1:0] group_base;
    logic             ovf;

    logic             accept;
    logic [WIDTH-1:0] grp_max;
    logic [1:0]       grp_win;
    logic             take;
    logic [WIDTH-1:0] new_max;
    logic [IDX_W-1:0] new_idx;
    logic [IDX_W:0]   idx_sum;
    logic [IDX_W:0]   base_sum;

    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MAXR_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign accept = s_valid && s_ready;

    // Strict greater-than keeps the lowest slot on ties; slot 0 is always filled in EVAL.
    always_comb begin
        grp_max = slot[0];
        grp_win = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (slot_vld[i] && gt(slot[i], grp_max)) begin
                grp_max = slot[i];
                grp_win = 2'(i);
            end
        end
        take     = first_grp || gt(grp_max, run_max);
        new_max  = take ? grp_max : run_max;
        idx_sum  = {1'b0, group_base} + {{(IDX_W-1){1'b0}}, grp_win};
        new_idx  = take ? (idx_sum[IDX_W] ? {IDX_W{1'b1}} : idx_sum[IDX_W-1:0]) : run_idx;
        base_sum = {1'b0, group_base} + (IDX_W+1)'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && (cnt == 2'd3 || s_last)) state_nxt = EVAL;
            EVAL:    state_nxt = last_seen ? DONE : FILL;
            DONE:    if (m_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready = (state == FILL) && !rst;
        m_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            slot_vld   <= '0;
            cnt        <= '0;
            last_seen  <= 1'b0;
            first_grp  <= 1'b1;
            run_max    <= '0;
            run_idx    <= '0;
            group_base <= '0;
            ovf        <= 1'b0;
            m_max      <= '0;
            m_idx      <= '0;
            m_ovf      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        slot[cnt]     <= s_data;
                        slot_vld[cnt] <= 1'b1;
                        cnt           <= cnt + 2'd1;
                        if (s_last) last_seen <= 1'b1;
                    end
                end
                EVAL: begin
                    run_max   <= new_max;
                    run_idx   <= new_idx;
                    first_grp <= 1'b0;
                    slot_vld  <= '0;
                    cnt       <= '0;
                    if (last_seen) begin
                        m_max <= new_max;
                        m_idx <= new_idx;
                        m_ovf <= ovf;
                    end else if (base_sum[IDX_W]) begin
                        group_base <= {IDX_W{1'b1}};
                        ovf        <= 1'b1;
                    end else begin
                        group_base <= base_sum[IDX_W-1:0];
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        last_seen  <= 1'b0;
                        first_grp  <= 1'b1;
                        run_max    <= '0;
                        run_idx    <= '0;
                        group_base <= '0;
                        ovf        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
